// File: rtl/imem_server_if.sv
// Instruction fetch bus between the CPU core and the instruction store.
// The CPU drives a byte PC; the store answers combinationally with a word.
interface imem_if #(
   parameter int NB_ADDR = 32,
   parameter int NB_WORD = 32
) ();
   logic [NB_ADDR-1:0] imem_pc;
   logic [NB_WORD-1:0] imem_instruction;

   modport mem (input imem_pc, output imem_instruction);
   modport cpu (output imem_pc, input imem_instruction);
endinterface

// File: rtl/imem_server.sv
// Instruction store with a byte-stream program loader.
// The CPU is held in reset while a program is loaded. A header of four
// little-endian bytes gives the word count N, then N words follow, each as
// four little-endian bytes. The store is released to the CPU in RUN.
//
// Load handshake: a byte moves on every rising edge where i_load_valid and
// o_load_ready are both 1. o_load_ready is a registered function of the
// state only. The source holds i_load_byte stable while i_load_valid is 1
// and the byte has not been taken.
module imem_server #(
   parameter int NB_WORD     = 32,
   parameter int NB_ADDR     = 32,
   parameter int DEPTH_WORDS = 1024
) (
   input  logic        i_clock,
   input  logic        i_reset_n,
   imem_if.mem         imem,
   input  logic        i_load_start,
   input  logic        i_run,
   input  logic        i_load_valid,
   input  logic [7:0]  i_load_byte,
   output logic        o_load_ready,
   output logic        o_cpu_reset,
   output logic        o_load_done,
   output logic        o_load_error,
   output logic [1:0]  o_state
);

   localparam int AW = $clog2(DEPTH_WORDS);
   localparam logic [31:0] NOP = 32'h0000_0013;

   typedef enum logic [1:0] {IDLE, HEADER, LOAD, RUN} state_t;

   state_t             state;
   logic [1:0]         rst_sync;
   logic               rst_n;
   logic               accept;
   logic [1:0]         lane;
   logic [23:0]        byte_buf;
   logic [31:0]        full_word;
   logic [AW:0]        wr_idx;
   logic [AW:0]        n_words;
   logic               last_word;
   logic               mem_we;
   logic [NB_ADDR-1:0] word_addr;
   logic               rd_ok;

   logic [NB_WORD-1:0] mem [DEPTH_WORDS];

   // Reset asserts immediately but releases two edges after i_reset_n rises.
   always_ff @(posedge i_clock or negedge i_reset_n) begin
      if (!i_reset_n) rst_sync <= 2'b00;
      else            rst_sync <= {rst_sync[0], 1'b1};
   end

   assign rst_n     = rst_sync[1];
   assign accept    = i_load_valid & o_load_ready;
   assign full_word = {i_load_byte, byte_buf};
   assign last_word = (wr_idx == n_words - (AW+1)'(1));
   assign mem_we    = (state == LOAD) && accept && (lane == 2'd3);
   assign o_state   = state;

   // Loader FSM: header parse, word assembly, CPU hold and status outputs.
   always_ff @(posedge i_clock or negedge rst_n) begin
      if (!rst_n) begin
         state        <= IDLE;
         o_cpu_reset  <= 1'b1;
         o_load_ready <= 1'b0;
         o_load_done  <= 1'b0;
         o_load_error <= 1'b0;
         lane         <= 2'd0;
         byte_buf     <= 24'd0;
         wr_idx       <= '0;
         n_words      <= '0;
      end else begin
         o_load_done <= 1'b0;
         if (accept && lane != 2'd3) byte_buf[8*lane +: 8] <= i_load_byte;
         case (state)
            IDLE: begin
               if (i_load_start) begin
                  state        <= HEADER;
                  o_load_ready <= 1'b1;
                  o_load_error <= 1'b0;
                  lane         <= 2'd0;
               end else if (i_run) begin
                  state       <= RUN;
                  o_cpu_reset <= 1'b0;
               end
            end
            HEADER: begin
               if (accept) begin
                  lane <= lane + 2'd1;
                  if (lane == 2'd3) begin
                     if (full_word == 32'd0) begin
                        state        <= RUN;
                        o_load_ready <= 1'b0;
                        o_cpu_reset  <= 1'b0;
                        o_load_done  <= 1'b1;
                     end else if (full_word > 32'(DEPTH_WORDS)) begin
                        state        <= IDLE;
                        o_load_ready <= 1'b0;
                        o_load_error <= 1'b1;
                     end else begin
                        state   <= LOAD;
                        n_words <= full_word[AW:0];
                        wr_idx  <= '0;
                     end
                  end
               end
            end
            LOAD: begin
               if (accept) begin
                  lane <= lane + 2'd1;
                  if (lane == 2'd3) begin
                     wr_idx <= wr_idx + (AW+1)'(1);
                     if (last_word) begin
                        state        <= RUN;
                        o_load_ready <= 1'b0;
                        o_cpu_reset  <= 1'b0;
                        o_load_done  <= 1'b1;
                     end
                  end
               end
            end
            RUN: begin
               if (i_load_start) begin
                  state        <= HEADER;
                  o_load_ready <= 1'b1;
                  o_cpu_reset  <= 1'b1;
                  lane         <= 2'd0;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   // Store write port; contents survive reset on purpose.
   always_ff @(posedge i_clock) begin
      if (mem_we) mem[wr_idx[AW-1:0]] <= NB_WORD'(full_word);
   end

   // Fetch port: aligned, in-range reads in RUN see the store, all else NOP.
   always_comb begin
      word_addr             = imem.imem_pc >> 2;
      rd_ok                 = (state == RUN) && (imem.imem_pc[1:0] == 2'b00)
                              && (word_addr < NB_ADDR'(DEPTH_WORDS));
      imem.imem_instruction = NB_WORD'(NOP);
      if (rd_ok) imem.imem_instruction = mem[imem.imem_pc[AW+1:2]];
   end

endmodule

// File: tb/tb_imem_server.sv
// Randomized bench for imem_server with a scoreboard on fetches and
// load-done pulses, and a behavioural model of the instruction store.
module tb_imem_server;
  localparam int DEPTH = 1024;
  localparam logic [31:0] NOP = 32'h0000_0013;

  // clock / reset
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n, load_start, run, load_valid;
  logic [7:0] load_byte;
  logic       load_ready, cpu_reset, load_done, load_error;
  logic [1:0] state_dbg;

  imem_if #(.NB_ADDR(32), .NB_WORD(32)) bus ();

  imem_server #(.NB_WORD(32), .NB_ADDR(32), .DEPTH_WORDS(DEPTH)) dut (
    .i_clock(clk), .i_reset_n(rst_n), .imem(bus),
    .i_load_start(load_start), .i_run(run), .i_load_valid(load_valid),
    .i_load_byte(load_byte), .o_load_ready(load_ready), .o_cpu_reset(cpu_reset),
    .o_load_done(load_done), .o_load_error(load_error), .o_state(state_dbg)
  );

  // reference model and scoreboard
  logic [31:0] ref_mem [DEPTH];
  bit          running;
  logic [31:0] prog [$];
  logic [31:0] exp_q [$];
  logic [31:0] pc_q [$];
  int          done_q [$];
  bit          rd_req;
  int          checks = 0;
  int          errors = 0;

  function automatic logic [31:0] model_read(input logic [31:0] pc);
    if (running && (pc % 4 == 0) && (pc / 4 < DEPTH)) return ref_mem[pc / 4];
    return NOP;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // monitor: fetch responses and load-done pulses
  always @(negedge clk) begin
    if (rd_req) begin
      logic [31:0] e, p;
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL fetch: response with empty expected queue");
      end else begin
        e = exp_q.pop_front();
        p = pc_q.pop_front();
        if (bus.imem_instruction !== e) begin
          errors++;
          $display("FAIL fetch pc=%h: got %h, expected %h", p, bus.imem_instruction, e);
        end
      end
    end
    if (load_done === 1'b1) begin
      checks++;
      if (done_q.size() == 0) begin
        errors++;
        $display("FAIL load_done: unexpected pulse");
      end else begin
        void'(done_q.pop_front());
      end
    end
  end

  // driver tasks
  task automatic send_byte(input logic [7:0] b, input bit rnd);
    bit acc = 1'b0;
    int tries = 0;
    while (!acc && tries < 200) begin
      @(negedge clk);
      load_byte  = b;
      load_valid = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      acc        = load_valid && load_ready;
      tries++;
      @(posedge clk);
    end
    #1 load_valid = 1'b0;
    if (!acc) check("byte_handshake_timeout", 32'(acc), 32'd1);
  endtask

  task automatic pulse_start();
    @(negedge clk); load_start = 1'b1;
    @(negedge clk); load_start = 1'b0;
    running = 1'b0;
  endtask

  task automatic pulse_run();
    @(negedge clk); run = 1'b1;
    @(negedge clk); run = 1'b0;
    running = 1'b1;
  endtask

  // header plus the words in prog; the loader must already be in HEADER
  task automatic send_load(input logic [31:0] n, input bit rnd);
    logic [31:0] w;
    if (n <= DEPTH) done_q.push_back(1);
    for (int k = 0; k < 4; k++) send_byte(8'(n >> (8 * k)), rnd);
    if (n >= 1 && n <= DEPTH) begin
      for (int i = 0; i < int'(n); i++) begin
        w = prog[i];
        for (int k = 0; k < 4; k++) send_byte(8'(w >> (8 * k)), rnd);
        ref_mem[i] = w;
      end
    end
    @(negedge clk);
    if (n <= DEPTH) begin
      running = 1'b1;
      check("cpu_reset_released", 32'(cpu_reset), 32'd0);
      check("ready_low_in_run", 32'(load_ready), 32'd0);
    end else begin
      running = 1'b0;
      check("error_set", 32'(load_error), 32'd1);
      check("cpu_reset_held", 32'(cpu_reset), 32'd1);
      check("ready_low_after_error", 32'(load_ready), 32'd0);
    end
  endtask

  task automatic rd(input logic [31:0] pc);
    @(posedge clk);
    #1;
    bus.imem_pc = pc;
    exp_q.push_back(model_read(pc));
    pc_q.push_back(pc);
    rd_req = 1'b1;
    @(negedge clk);
    #1 rd_req = 1'b0;
  endtask

  task automatic fill_random(input int n);
    prog.delete();
    for (int i = 0; i < n; i++) prog.push_back($urandom());
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  // stimulus
  initial begin
    logic [31:0] w0;
    rst_n = 1'b0; load_start = 1'b0; run = 1'b0; load_valid = 1'b0;
    load_byte = 8'h00; bus.imem_pc = '0; rd_req = 1'b0; running = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_cpu_reset", 32'(cpu_reset), 32'd1);
    check("rst_ready", 32'(load_ready), 32'd0);
    check("rst_done", 32'(load_done), 32'd0);
    check("rst_error", 32'(load_error), 32'd0);

    // reset release is synchronized: a held i_run must not act on edge 1
    @(negedge clk); rst_n = 1'b1; run = 1'b1;
    @(posedge clk); #1;
    check("sync_hold_edge1", 32'(cpu_reset), 32'd1);
    run = 1'b0;
    repeat (4) @(posedge clk);

    // directed two-word program
    pulse_start();
    check("ready_in_header", 32'(load_ready), 32'd1);
    prog = '{32'h0010_0513, 32'h0020_0593};
    send_load(32'd2, 1'b0);
    rd(32'd4); rd(32'd0);

    // empty program: straight to RUN, store unchanged
    pulse_start();
    check("reload_cpu_reset", 32'(cpu_reset), 32'd1);
    send_load(32'd0, 1'b0);
    rd(32'd0); rd(32'd4);

    // same program with a stuttering valid
    pulse_start();
    prog = '{32'h0010_0513, 32'h0020_0593};
    send_load(32'd2, 1'b1);
    rd(32'd0); rd(32'd4);

    // misaligned and out-of-range fetches in RUN
    rd(32'h2); rd(32'h1000); rd(32'hFFFF_FFFC);

    // random programs with random valid gaps
    for (int t = 0; t < 4; t++) begin
      int n;
      n = $urandom_range(1, 12);
      pulse_start();
      fill_random(n);
      send_load(32'(n), 1'b1);
      for (int i = 0; i < n; i++) rd(32'(4 * i));
      rd(32'(4 * $urandom_range(0, n - 1) + $urandom_range(1, 3)));
    end

    // oversize header: error, CPU held, store not served
    pulse_start();
    send_load(32'd1025, 1'b0);
    rd(32'd0);
    pulse_start();
    check("error_cleared", 32'(load_error), 32'd0);
    check("ready_after_restart", 32'(load_ready), 32'd1);

    // full-depth load exercises the top write index
    fill_random(DEPTH);
    send_load(32'(DEPTH), 1'b0);
    rd(32'd0); rd(32'(4 * (DEPTH - 1))); rd(32'(4 * DEPTH));
    for (int i = 0; i < 8; i++) rd(32'(4 * $urandom_range(0, DEPTH - 1)));

    // reset in the middle of a load keeps words already written
    pulse_start();
    w0 = $urandom();
    for (int k = 0; k < 4; k++) send_byte(8'(32'd3 >> (8 * k)), 1'b0);
    for (int k = 0; k < 4; k++) send_byte(8'(w0 >> (8 * k)), 1'b0);
    ref_mem[0] = w0;
    send_byte(8'hA5, 1'b0);
    send_byte(8'h5A, 1'b0);
    @(negedge clk); rst_n = 1'b0;
    #1;
    running = 1'b0;
    check("abort_cpu_reset", 32'(cpu_reset), 32'd1);
    check("abort_ready", 32'(load_ready), 32'd0);
    check("abort_done", 32'(load_done), 32'd0);
    @(negedge clk); rst_n = 1'b1;
    repeat (4) @(posedge clk);
    pulse_run();
    check("run_cpu_reset", 32'(cpu_reset), 32'd0);
    rd(32'd0); rd(32'd4); rd(32'd8);

    repeat (3) @(posedge clk);
    check("done_queue_empty", 32'(done_q.size()), 32'd0);
    check("fetch_queue_empty", 32'(exp_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/imem_server.md
IMEM_SERVER -- requirements
Module: imem_server

Interface
REQ-001 Parameter NB_WORD, default 32, instruction/data word width.
REQ-002 Parameter NB_ADDR, default 32, PC width on imem_if.
REQ-003 Parameter DEPTH_WORDS, default 1024, instruction store depth in words (power of two).
REQ-004 i_clock  input  1  sole clock; all state on its rising edge.
REQ-005 i_reset_n  input  1  reset, asynchronous, active-low.
REQ-006 IMEM_IF  imem_if.mem modport  --  imem_pc input NB_ADDR; imem_instruction output NB_WORD.
REQ-007 i_load_start  input  1  begin a program load.
REQ-008 i_run  input  1  release CPU on current store contents without loading.
REQ-009 i_load_valid  input  1  i_load_byte valid this cycle.
REQ-010 i_load_byte  input  8  load stream byte.
REQ-011 o_load_ready  output  1  block accepts a load byte this cycle.
REQ-012 o_cpu_reset  output  1  active-high hold for the CPU core.
REQ-013 o_load_done  output  1  one-cycle pulse, load completed.
REQ-014 o_load_error  output  1  sticky, header word count exceeded DEPTH_WORDS.

Function
REQ-015 FSM states SHALL be IDLE, HEADER, LOAD, RUN.
REQ-016 A byte SHALL be accepted only on a cycle with i_load_valid=1 and o_load_ready=1.
REQ-017 o_load_ready SHALL be 1 in HEADER and LOAD, 0 in IDLE and RUN; registered, no combinational path from i_load_valid.
REQ-018 IDLE: i_load_start=1 -> HEADER, clearing o_load_error; else i_run=1 -> RUN; i_load_start has priority.
REQ-019 HEADER: four accepted bytes, little-endian, form 32-bit word count N; FSM transitions on the edge accepting byte 3.
REQ-020 N=0 -> RUN with o_load_done pulse; N>DEPTH_WORDS -> IDLE, o_load_error=1; otherwise -> LOAD with write index 0.
REQ-021 LOAD: bytes assembled little-endian (byte k -> bits 8k+7:8k); on the edge accepting byte 3 of a word, the word SHALL be written at the write index, index increments.
REQ-022 The word written at index N-1 SHALL transition LOAD -> RUN and pulse o_load_done in the following cycle.
REQ-023 i_load_start in RUN SHALL transition to HEADER (reload); i_load_start in HEADER/LOAD SHALL be ignored.
REQ-024 o_cpu_reset SHALL be registered, 0 exactly while state is RUN, 1 otherwise.
REQ-025 imem_instruction SHALL be combinational: mem[imem_pc[log2(DEPTH_WORDS)+1:2]] when state is RUN, imem_pc[1:0]=0 and imem_pc/4 < DEPTH_WORDS.
REQ-026 Otherwise imem_instruction SHALL return NOP 32'h0000_0013.
REQ-027 A word written on edge t SHALL be readable from cycle t+1.
REQ-028 Byte-lane counter 2 bits, wraps 3->0; write index width log2(DEPTH_WORDS)+1, no wrap possible given REQ-020.

Reset
REQ-029 On i_reset_n=0, asynchronously: state IDLE, o_cpu_reset=1, o_load_ready=0, o_load_done=0, o_load_error=0, byte/word counters 0.
REQ-030 Store contents SHALL NOT be reset; a load aborted by reset leaves earlier written words intact.
REQ-031 Reset deassertion SHALL be synchronized internally; first state change no earlier than the second rising edge after deassertion.

Verification
REQ-032 Reset, i_load_start, header 02 00 00 00, bytes 13 05 10 00 93 05 20 00 -> mem[0]=0x00100513, mem[1]=0x00200593, o_load_done one pulse, o_cpu_reset falls, imem_pc=4 returns 0x00200593.
REQ-033 Header 00 00 00 00 -> RUN immediately, o_load_done pulses, store unchanged.
REQ-034 Header 01 04 00 00 (N=1025, DEPTH 1024) -> IDLE, o_load_error=1, o_cpu_reset stays 1; next i_load_start clears o_load_error.
REQ-035 i_load_valid toggled randomly, bytes held stable -> only handshaked bytes counted; result identical to REQ-032.
REQ-036 In RUN: imem_pc=0x2, 0x1000, then during IDLE imem_pc=0 -> each returns 0x00000013.
REQ-037 Assert i_reset_n=0 mid-LOAD after word 0 written -> immediate IDLE, o_cpu_reset=1, mem[0] retained; then i_run -> RUN, imem_pc=0 returns mem[0].
